// File: rtl/burst_rd_seq_pkg.sv
// Shared types and default widths for the burst read sequencer slice.
// The state encoding is fixed so that WAIT and FIN differ from IDLE/ISSUE in bit 1.
package burst_rd_pkg;

   localparam int AW_DEF  = 8;
   localparam int LW_DEF  = 4;
   localparam int DW_DEF  = 8;
   localparam int TMO_DEF = 15;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ISSUE = 2'b01,
      WAIT  = 2'b11,
      FIN   = 2'b10
   } state_e;

endpackage

// File: rtl/burst_rd_seq_if.sv
// Request, read-controller and result signals of the burst read sequencer.
// The sequencer itself connects through the slave modport; its driver uses master.
interface burst_rd_seq_if
   import burst_rd_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int LW = LW_DEF,
   parameter int DW = DW_DEF
);

   logic          req;
   logic [AW-1:0] req_addr;
   logic [LW-1:0] req_len;
   logic          req_rdy;
   logic          go;
   logic [AW-1:0] addr;
   logic          ds;
   logic [DW-1:0] rd_data;
   logic          beat_vld;
   logic [DW-1:0] beat_data;
   logic          busy;
   logic          cmplt;
   logic          err;

   modport slave (
      input  req, req_addr, req_len, ds, rd_data,
      output req_rdy, go, addr, beat_vld, beat_data, busy, cmplt, err
   );

   modport master (
      output req, req_addr, req_len, ds, rd_data,
      input  req_rdy, go, addr, beat_vld, beat_data, busy, cmplt, err
   );

endinterface

// File: rtl/burst_rd_seq_tmo_cnt.sv
// Per-beat watchdog: cleared when a beat is issued, counts while waiting for ds.
// expired_o flags the last cycle the sequencer is allowed to wait.
module rd_tmo_cnt #(
   parameter int TMO = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int CW = $clog2(TMO + 1);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (en_i) begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

   assign expired_o = (cnt_q == CW'(TMO - 1));

endmodule

// File: rtl/burst_rd_seq.sv
// Burst read sequencer: turns one {address, length} request into a chain of
// single-beat go/ds transactions, with a watchdog that aborts a stalled beat.
module burst_rd_seq
   import burst_rd_pkg::*;
#(
   parameter int AW  = AW_DEF,
   parameter int LW  = LW_DEF,
   parameter int DW  = DW_DEF,
   parameter int TMO = TMO_DEF
) (
   input  logic           clk,
   input  logic           rst_n,
   burst_rd_seq_if.slave  bus
);

   state_e        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [LW-1:0] rem_q, rem_d;
   logic [DW-1:0] beatData_q, beatData_d;
   logic          beatVld_q, beatVld_d;
   logic          errFlag_q, errFlag_d;
   logic          tmrClr, tmrEn, tmrExpired;

   rd_tmo_cnt #(.TMO(TMO)) u_tmo (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr_i     (tmrClr),
      .en_i      (tmrEn),
      .expired_o (tmrExpired)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         rem_q      <= '0;
         beatData_q <= '0;
         beatVld_q  <= 1'b0;
         errFlag_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         rem_q      <= rem_d;
         beatData_q <= beatData_d;
         beatVld_q  <= beatVld_d;
         errFlag_q  <= errFlag_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      rem_d      = rem_q;
      beatData_d = beatData_q;
      beatVld_d  = 1'b0;
      errFlag_d  = errFlag_q;
      tmrClr     = 1'b0;
      tmrEn      = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.req) begin
               addr_d  = bus.req_addr;
               rem_d   = bus.req_len;
               state_d = (bus.req_len == '0) ? FIN : ISSUE;
            end
         end
         ISSUE: begin
            tmrClr  = 1'b1;
            state_d = WAIT;
         end
         WAIT: begin
            tmrEn = 1'b1;
            // ds is checked first so a strobe on the expiry cycle still counts
            if (bus.ds) begin
               beatData_d = bus.rd_data;
               beatVld_d  = 1'b1;
               addr_d     = addr_q + AW'(1);
               rem_d      = rem_q - LW'(1);
               state_d    = (rem_q == LW'(1)) ? FIN : ISSUE;
            end else if (tmrExpired) begin
               errFlag_d = 1'b1;
               state_d   = FIN;
            end
         end
         FIN: begin
            errFlag_d = 1'b0;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.req_rdy   = (state_q == IDLE);
   assign bus.go        = (state_q == ISSUE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.cmplt     = (state_q == FIN);
   assign bus.err       = (state_q == FIN) && errFlag_q;
   assign bus.addr      = addr_q;
   assign bus.beat_vld  = beatVld_q;
   assign bus.beat_data = beatData_q;

endmodule

// File: tb/tb_burst_rd_seq.sv
// Bench for burst_rd_seq: a table of bursts against a delayed ds responder,
// with a scoreboard of expected beat addresses, data and completion status.
module tb_burst_rd_seq;

   typedef struct {
      logic [7:0] addr;
      logic [3:0] len;
      int         delay;
      int         expLat;
      logic       expErr;
   } vec_t;

   logic clk;
   logic rst_n;
   int   vectors;
   int   miscompares;
   int   respDelay;
   int   waitCnt;
   logic spuriousDs;
   logic [7:0] lastExpData;

   logic [7:0] expAddrQ[$];
   logic [7:0] expDataQ[$];
   logic       expErrQ[$];

   vec_t vecs[8];

   burst_rd_seq_if #(.AW(8), .LW(4), .DW(8)) bus ();

   burst_rd_seq #(.AW(8), .LW(4), .DW(8), .TMO(15)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] dataOf(input logic [7:0] a);
      return {a[3:0], a[7:4]} ^ 8'h3C;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Read-controller stand-in: answers each go with ds after respDelay cycles (0 = never)
   always @(negedge clk) begin
      if (!rst_n) begin
         waitCnt      = 0;
         bus.ds       = 1'b0;
         bus.rd_data  = '0;
      end else begin
         bus.ds = 1'b0;
         if (waitCnt != 0) begin
            waitCnt--;
            if (waitCnt == 0) begin
               bus.ds      = 1'b1;
               bus.rd_data = dataOf(bus.addr);
            end
         end else if (bus.go && respDelay != 0) begin
            waitCnt = respDelay;
         end
         if (spuriousDs) begin
            bus.ds      = 1'b1;
            bus.rd_data = 8'hEE;
         end
      end
   end

   // Scoreboard: every go, beat and completion must match the next expected entry
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.go) begin
            if (expAddrQ.size() == 0) checkOutput("unexpectedGo", 32'(bus.addr), 32'hFFFF);
            else checkOutput("goAddr", 32'(bus.addr), 32'(expAddrQ.pop_front()));
         end
         if (bus.beat_vld) begin
            if (expDataQ.size() == 0) checkOutput("unexpectedBeat", 32'(bus.beat_data), 32'hFFFF);
            else begin
               lastExpData = expDataQ.pop_front();
               checkOutput("beatData", 32'(bus.beat_data), 32'(lastExpData));
            end
         end
         if (bus.cmplt) begin
            if (expErrQ.size() == 0) checkOutput("unexpectedCmplt", 32'(bus.err), 32'hFFFF);
            else checkOutput("cmpltErr", 32'(bus.err), 32'(expErrQ.pop_front()));
         end
      end
   end

   task automatic applyStimulus(input logic [7:0] addr, input logic [3:0] len, input int delay,
                                input int expLat, input logic expErr, input bit midReq);
      int  cyc;
      bit  done;
      respDelay = delay;
      expErrQ.push_back(expErr);
      if (len != 0) begin
         if (expErr) expAddrQ.push_back(addr);
         else begin
            for (int i = 0; i < int'(len); i++) begin
               expAddrQ.push_back(addr + 8'(i));
               expDataQ.push_back(dataOf(addr + 8'(i)));
            end
         end
      end
      cyc = 0;
      while (!bus.req_rdy && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      checkOutput("reqRdyBefore", 32'(bus.req_rdy), 32'd1);
      bus.req      = 1'b1;
      bus.req_addr = addr;
      bus.req_len  = len;
      @(posedge clk);
      #1 bus.req = 1'b0;
      cyc  = 0;
      done = 0;
      while (!done && cyc < 400) begin
         @(negedge clk);
         cyc++;
         if (bus.cmplt) done = 1;
         if (cyc == 1 && len != 0) begin
            checkOutput("busyInBurst", 32'(bus.busy), 32'd1);
            checkOutput("reqRdyInBurst", 32'(bus.req_rdy), 32'd0);
         end
         if (midReq && cyc == 4) begin
            bus.req      = 1'b1;
            bus.req_addr = 8'h99;
            bus.req_len  = 4'd2;
         end else begin
            bus.req = 1'b0;
         end
      end
      if (!done) checkOutput("cmpltTimeout", 32'd0, 32'd1);
      else checkOutput("latency", 32'(cyc), 32'(expLat));
      @(negedge clk);
      checkOutput("reqRdyAfter", 32'(bus.req_rdy), 32'd1);
      checkOutput("busyAfter", 32'(bus.busy), 32'd0);
      checkOutput("addrQLeft", 32'(expAddrQ.size()), 32'd0);
      checkOutput("dataQLeft", 32'(expDataQ.size()), 32'd0);
      checkOutput("errQLeft", 32'(expErrQ.size()), 32'd0);
   endtask

   initial begin
      vectors      = 0;
      miscompares  = 0;
      respDelay    = 0;
      spuriousDs   = 1'b0;
      lastExpData  = '0;
      rst_n        = 1'b0;
      bus.req      = 1'b0;
      bus.req_addr = '0;
      bus.req_len  = '0;

      vecs[0] = '{8'h10, 4'd3,  3, 13, 1'b0};
      vecs[1] = '{8'hFE, 4'd4,  2, 13, 1'b0};
      vecs[2] = '{8'h33, 4'd0,  3,  1, 1'b0};
      vecs[3] = '{8'h50, 4'd2,  0, 17, 1'b1};
      vecs[4] = '{8'h60, 4'd2,  1,  5, 1'b0};
      vecs[5] = '{8'h20, 4'd1, 15, 17, 1'b0};
      vecs[6] = '{8'hA0, 4'd15, 1, 31, 1'b0};
      vecs[7] = '{8'h05, 4'd2, 14, 31, 1'b0};

      repeat (3) @(negedge clk);
      checkOutput("rstGo", 32'(bus.go), 32'd0);
      checkOutput("rstBusy", 32'(bus.busy), 32'd0);
      checkOutput("rstCmplt", 32'(bus.cmplt), 32'd0);
      checkOutput("rstErr", 32'(bus.err), 32'd0);
      checkOutput("rstBeatVld", 32'(bus.beat_vld), 32'd0);
      checkOutput("rstAddr", 32'(bus.addr), 32'd0);
      checkOutput("rstBeatData", 32'(bus.beat_data), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("rstReqRdy", 32'(bus.req_rdy), 32'd1);

      for (int v = 0; v < 8; v++) begin
         applyStimulus(vecs[v].addr, vecs[v].len, vecs[v].delay, vecs[v].expLat, vecs[v].expErr, 1'b0);
      end

      // A ds strobe while idle must not produce a beat or disturb beat_data
      @(posedge clk);
      #2 spuriousDs = 1'b1;
      @(posedge clk);
      #2 spuriousDs = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("spurBeatVld", 32'(bus.beat_vld), 32'd0);
         checkOutput("spurBusy", 32'(bus.busy), 32'd0);
      end
      checkOutput("spurBeatData", 32'(bus.beat_data), 32'(lastExpData));

      applyStimulus(8'h30, 4'd3, 2, 10, 1'b0, 1'b1);

      // Reset during the wait of beat 2 of a 4-beat burst
      respDelay = 5;
      expAddrQ.push_back(8'h40);
      expAddrQ.push_back(8'h41);
      expDataQ.push_back(dataOf(8'h40));
      @(negedge clk);
      bus.req      = 1'b1;
      bus.req_addr = 8'h40;
      bus.req_len  = 4'd4;
      @(posedge clk);
      #1 bus.req = 1'b0;
      repeat (9) @(negedge clk);
      checkOutput("preRstBusy", 32'(bus.busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("midRstGo", 32'(bus.go), 32'd0);
      checkOutput("midRstBusy", 32'(bus.busy), 32'd0);
      checkOutput("midRstCmplt", 32'(bus.cmplt), 32'd0);
      checkOutput("midRstErr", 32'(bus.err), 32'd0);
      checkOutput("midRstBeatVld", 32'(bus.beat_vld), 32'd0);
      checkOutput("midRstAddr", 32'(bus.addr), 32'd0);
      checkOutput("midRstBeatData", 32'(bus.beat_data), 32'd0);
      checkOutput("midRstAddrQ", 32'(expAddrQ.size()), 32'd0);
      checkOutput("midRstDataQ", 32'(expDataQ.size()), 32'd0);
      expAddrQ.delete();
      expDataQ.delete();
      expErrQ.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("postRstReqRdy", 32'(bus.req_rdy), 32'd1);
      applyStimulus(8'h77, 4'd1, 2, 4, 1'b0, 1'b0);

      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
